// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU decoder, NZCV flag register and
// condition check, with PC/register/memory writes gated by the instruction condition.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t     state, state_nxt;
  logic       nextpc, regw, memw, branch, aluop;
  logic [3:0] flags;
  logic       condex, cond_ok;
  logic [2:0] dp_ctl;
  logic       dp_nowrite, dp_cv, dp_s;
  logic [1:0] flagw;
  logic       nowrite, pcs;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = FETCH;
    unique case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: case (Op)
        2'b01:   state_nxt = MEMADR;
        2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
        2'b10:   state_nxt = BRANCH;
        default: state_nxt = FETCH;
      endcase
      MEMADR: state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXECR,
      EXECI:  state_nxt = ALUWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    nextpc = 1'b0; regw = 1'b0; memw = 1'b0; branch = 1'b0; aluop = 1'b0;
    IRWrite = 1'b0; AdrSrc = 1'b0; RegSrc = 2'b00;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
    unique case (state)
      FETCH:  begin IRWrite = 1'b1; nextpc = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        RegSrc  = (Op == 2'b10) ? 2'b01 : ((Op == 2'b01) ? 2'b10 : 2'b00);
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB:  begin ResultSrc = 2'b01; regw = 1'b1; end
      MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; end
      EXECR:  aluop = 1'b1;
      EXECI:  begin ALUSrcB = 2'b01; aluop = 1'b1; end
      ALUWB:  regw = 1'b1;
      BRANCH: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default: ;
    endcase
  end

  // Decode the command unconditionally so NoWrite is still valid in ALUWB.
  always_comb begin
    dp_ctl = 3'b000; dp_nowrite = 1'b0; dp_cv = 1'b0; dp_s = Funct[0];
    case (Funct[4:1])
      4'b0100: begin dp_ctl = 3'b000; dp_cv = 1'b1; end
      4'b0010: begin dp_ctl = 3'b001; dp_cv = 1'b1; end
      4'b0000: dp_ctl = 3'b010;
      4'b1100: dp_ctl = 3'b011;
      4'b0001: dp_ctl = 3'b100;
      4'b1101: dp_ctl = 3'b101;
      4'b1010: begin dp_ctl = 3'b001; dp_cv = 1'b1; dp_nowrite = 1'b1; dp_s = 1'b1; end
      default: begin dp_nowrite = 1'b1; dp_s = 1'b0; end
    endcase
  end

  assign ALUControl = aluop ? dp_ctl : 3'b000;
  assign flagw      = aluop ? {dp_s, dp_s & dp_cv} : 2'b00;
  assign nowrite    = (Op == 2'b00) & dp_nowrite;

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    cond_ok = 1'b0;
    case (Cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = ~z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      flags  <= 4'b0000;
      condex <= 1'b0;
    end else begin
      if (state == DECODE)     condex      <= cond_ok;
      if (flagw[1] & condex)   flags[3:2]  <= ALUFlags[3:2];
      if (flagw[0] & condex)   flags[1:0]  <= ALUFlags[1:0];
    end

  assign pcs      = ((Rd == 4'd15) & regw) | branch;
  assign PCWrite  = nextpc | (pcs & condex);
  assign RegWrite = regw & condex & ~nowrite;
  assign MemWrite = memw & condex;
  assign ImmSrc   = Op;
endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios then random
// instructions, each cycle compared against a phase-level reference model.
module tb_mc_controller;
  logic       clk, reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMWR = 5,
                 PER = 6, PEI = 7, PAW = 8, PB = 9;

  // reference model architectural state
  logic [3:0] mflags;
  logic       mcondex;

  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {ALUControl, suppress-write, writes NZ, writes CV} for a data-processing Funct
  function automatic logic [5:0] dp_info(input logic [5:0] f);
    logic [3:0] cmd;
    logic       s;
    cmd = f[4:1];
    s   = f[0];
    case (cmd)
      4'b0100: return {3'd0, 1'b0, s, s};       // ADD
      4'b0010: return {3'd1, 1'b0, s, s};       // SUB
      4'b0000: return {3'd2, 1'b0, s, 1'b0};    // AND
      4'b1100: return {3'd3, 1'b0, s, 1'b0};    // ORR
      4'b0001: return {3'd4, 1'b0, s, 1'b0};    // EOR
      4'b1101: return {3'd5, 1'b0, s, 1'b0};    // MOV
      4'b1010: return {3'd1, 1'b1, 1'b1, 1'b1}; // CMP
      default: return {3'd0, 1'b1, 1'b0, 1'b0}; // NOP
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, " IRWrite"},    {3'b0, IRWrite},   4'd1);
    chk({pfx, " PCWrite"},    {3'b0, PCWrite},   4'd1);
    chk({pfx, " RegWrite"},   {3'b0, RegWrite},  4'd0);
    chk({pfx, " MemWrite"},   {3'b0, MemWrite},  4'd0);
    chk({pfx, " AdrSrc"},     {3'b0, AdrSrc},    4'd0);
    chk({pfx, " ALUSrcB"},    {2'b0, ALUSrcB},   4'd2);
    chk({pfx, " ResultSrc"},  {2'b0, ResultSrc}, 4'd2);
    chk({pfx, " ALUControl"}, {1'b0, ALUControl}, 4'd0);
  endtask

  // Runs one instruction from its FETCH cycle. fl_fix forces ALUFlags; abort_at
  // (phase index) pulls reset low in that cycle and returns once it is released.
  task automatic run_instr(input logic [3:0] cc, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic fl_fix, input logic [3:0] fl,
                           input int abort_at);
    int seq[$];
    logic [5:0] di;
    Cond = cc; Op = op; Funct = fn; Rd = rd;
    di = dp_info(fn);
    seq = '{PF, PD};
    case (op)
      2'b01: if (fn[0]) seq = {seq, PMA, PMR, PMWB}; else seq = {seq, PMA, PMWR};
      2'b00: seq = {seq, fn[5] ? PEI : PER, PAW};
      2'b10: seq.push_back(PB);
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      logic irw, npc, adr, regw, memw, br;
      logic [1:0] rsrc, sa, sb, res;
      logic [2:0] alu;
      string t;
      int ph;
      ph = seq[i];
      irw = 0; npc = 0; adr = 0; regw = 0; memw = 0; br = 0;
      rsrc = 0; sa = 0; sb = 0; res = 0; alu = 0;
      case (ph)
        PF:   begin irw = 1; npc = 1; sa = 1; sb = 2; res = 2; end
        PD:   begin sa = 1; sb = 2; res = 2; rsrc = (op == 2) ? 2'd1 : ((op == 1) ? 2'd2 : 2'd0); end
        PMA:  sb = 1;
        PMR:  adr = 1;
        PMWB: begin res = 1; regw = 1; end
        PMWR: begin adr = 1; memw = 1; end
        PER:  alu = di[5:3];
        PEI:  begin sb = 1; alu = di[5:3]; end
        PAW:  regw = 1;
        PB:   begin sa = 2; sb = 1; res = 2; br = 1; end
        default: ;
      endcase
      ALUFlags = fl_fix ? fl : 4'($urandom);
      @(negedge clk);
      t = $sformatf("i%0b_%0b_%0h ph%0d", op, fn, cc, ph);
      chk({t, " PCWrite"},  {3'b0, PCWrite},
          {3'b0, npc | ((((rd == 15) && regw) || br) && mcondex)});
      chk({t, " RegWrite"}, {3'b0, RegWrite},
          {3'b0, regw && mcondex && !(op == 0 && di[2])});
      chk({t, " MemWrite"}, {3'b0, MemWrite}, {3'b0, memw && mcondex});
      chk({t, " IRWrite"},  {3'b0, IRWrite},  {3'b0, irw});
      chk({t, " AdrSrc"},   {3'b0, AdrSrc},   {3'b0, adr});
      chk({t, " RegSrc"},   {2'b0, RegSrc},   {2'b0, rsrc});
      chk({t, " ALUSrcA"},  {2'b0, ALUSrcA},  {2'b0, sa});
      chk({t, " ALUSrcB"},  {2'b0, ALUSrcB},  {2'b0, sb});
      chk({t, " ResultSrc"},{2'b0, ResultSrc},{2'b0, res});
      chk({t, " ImmSrc"},   {2'b0, ImmSrc},   {2'b0, op});
      chk({t, " ALUControl"},{1'b0, ALUControl},{1'b0, alu});
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset_outputs("abort");
        mflags = 4'b0; mcondex = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        return;
      end
      @(posedge clk);
      if (ph == PD) mcondex = cond_true(cc, mflags);
      if ((ph == PER || ph == PEI) && mcondex) begin
        if (di[1]) mflags[3:2] = ALUFlags[3:2];
        if (di[0]) mflags[1:0] = ALUFlags[1:0];
      end
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Cond = 0; Op = 0; Funct = 0; Rd = 0; ALUFlags = 0;
    mflags = 4'b0; mcondex = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b1;

    // ADDS register form, then immediate form; branches probe the stored flags
    run_instr(4'hE, 2'b00, 6'b001001, 4'd2, 1, 4'b0110, -1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);   // BEQ taken
    run_instr(4'h2, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);   // BCS taken
    run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);   // BMI not taken
    run_instr(4'hE, 2'b00, 6'b101001, 4'd2, 1, 4'b1001, -1);
    run_instr(4'hA, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);   // BGE taken
    // CMP sets Z; BEQ taken, BNE not; STRNE suppressed; LDR; MOV PC
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 1, 4'b0100, -1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);
    run_instr(4'h1, 2'b01, 6'b011000, 4'd4, 0, 4'b0, -1);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 0, 4'b0, -1);
    run_instr(4'hE, 2'b00, 6'b011010, 4'd15, 0, 4'b0, -1);
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 0, 4'b0, -1);
    // Reset in EXECR with Z still set: flags must clear, so BEQ then falls through
    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 0, 4'b0, 2);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 0, 4'b0, -1);

    for (int k = 0; k < 150; k++) begin
      logic [3:0] rc, rr;
      rc = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(rc, 2'($urandom), 6'($urandom), rr, 0, 4'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
